uart_prog_loader: RTL

Boot-time program loader for the user-project core. It receives a serial byte stream on the UART pin driven by the host programmer and assembles bytes into little-endian instruction words. Each word is written to instruction memory at consecutive word addresses, and the core is held in reset until an end-of-program word arrives. Width, memory depth, baud divisor and terminator are parameters, which lets one block serve every memory configuration.

---
 rtl/uart_prog_pkg.sv | 20 ++
 rtl/uart_rx_core.sv | 136 +++++++++++++
 rtl/uart_prog_loader.sv | 113 +++++++++++
 3 files changed

// File: rtl/uart_prog_pkg.sv
// Shared types and constants for the UART program loader.
// Receiver states, bit-timer sizing helper and the default terminator word.
package uart_prog_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic [31:0] END_WORD_DEFAULT = 32'h0000_0FFF;

  // Bit-timer width; the timer counts 0..CLKS_PER_BIT-1.
  function automatic int unsigned bit_timer_w(input int unsigned clks);
    return (clks < 2) ? 1 : $clog2(clks);
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART byte receiver: 2-flop synchroniser, bit timer and receive FSM.
// Even-parity framing is added when UART_PROG_PARITY_EN is defined.
module uart_rx_core
  import uart_prog_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
`ifdef UART_PROG_PARITY_EN
  output logic       parity_err_o,
`endif
  output logic       frame_err_o
);

  localparam int unsigned TW = bit_timer_w(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

  logic [1:0]    sync_q;
  logic          rx_prev_q;
  logic          rx_s;
  rx_state_e     state_q, state_d;
  logic [TW-1:0] timer_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          sample_c;
  logic          tick_half;
  logic          tick_full;
`ifdef UART_PROG_PARITY_EN
  logic          par_bad_q;
`endif

  assign rx_s      = sync_q[1];
  assign tick_half = (timer_q == HALF_M1);
  assign tick_full = (timer_q == FULL_M1);
  assign byte_o    = shift_q;

  // Synchroniser and edge-detect history; idle level is high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], rx_i};
      rx_prev_q <= sync_q[1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    sample_c     = 1'b0;
    byte_valid_o = 1'b0;
    frame_err_o  = 1'b0;
`ifdef UART_PROG_PARITY_EN
    parity_err_o = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s) state_d = START;
      end
      START: begin
        if (tick_half) begin
          sample_c = 1'b1;
          state_d  = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick_full) begin
          sample_c = 1'b1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_PROG_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_PROG_PARITY_EN
      PARITY: begin
        if (tick_full) begin
          sample_c     = 1'b1;
          parity_err_o = rx_s ^ (^shift_q);
          state_d      = STOP;
        end
      end
`endif
      STOP: begin
        if (tick_full) begin
          sample_c    = 1'b1;
          state_d     = IDLE;
          frame_err_o = ~rx_s;
`ifdef UART_PROG_PARITY_EN
          byte_valid_o = rx_s & ~par_bad_q;
`else
          byte_valid_o = rx_s;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit timer restarts on every sample so each bit is timed from the previous one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      if (state_q == IDLE || sample_c) timer_q <= '0;
      else                             timer_q <= timer_q + TW'(1);
      if (state_q == IDLE)                  bit_cnt_q <= '0;
      else if (state_q == DATA && sample_c) bit_cnt_q <= bit_cnt_q + 3'd1;
      if (state_q == DATA && sample_c) shift_q <= {rx_s, shift_q[7:1]};
    end
  end

`ifdef UART_PROG_PARITY_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                            par_bad_q <= 1'b0;
    else if (state_q == IDLE)               par_bad_q <= 1'b0;
    else if (state_q == PARITY && sample_c) par_bad_q <= parity_err_o;
  end
`endif

endmodule

// File: rtl/uart_prog_loader.sv
// Boot loader: assembles UART bytes into little-endian words and writes them to
// instruction memory, holding the core in reset until END_WORD. Option: UART_PROG_PARITY_EN.
module uart_prog_loader
  import uart_prog_pkg::*;
#(
  parameter int unsigned          CLKS_PER_BIT = 16,
  parameter int unsigned          WORD_W       = 32,
  parameter int unsigned          ADDR_W       = 10,
  parameter logic [WORD_W-1:0]    END_WORD     = WORD_W'(END_WORD_DEFAULT)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rx_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  output logic              core_rst_no,
  output logic              done_o,
  output logic              frame_err_o,
`ifdef UART_PROG_PARITY_EN
  output logic              parity_err_o,
`endif
  output logic              ovf_err_o
);

  localparam int unsigned LANES = WORD_W / 8;
  localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned AW1   = ADDR_W + 1;

  logic [7:0]        rx_byte;
  logic              rx_valid;
  logic              rx_frame_err;
  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] word_c;
  logic [LW-1:0]     lane_q;
  logic              lane_last;
  logic [AW1-1:0]    addr_cnt_q;
  logic              accept;
`ifdef UART_PROG_PARITY_EN
  logic              rx_parity_err;
`endif

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rx_i        (rx_i),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid),
`ifdef UART_PROG_PARITY_EN
    .parity_err_o(rx_parity_err),
`endif
    .frame_err_o (rx_frame_err)
  );

  assign accept    = rx_valid & ~done_o;
  assign lane_last = (lane_q == LW'(LANES - 1));

  // Word with the incoming byte merged into the current lane.
  always_comb begin
    word_c = word_q;
    word_c[{lane_q, 3'b000} +: 8] = rx_byte;
  end

  // Address count carries one extra bit so "memory full" is distinct from wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q      <= '0;
      lane_q      <= '0;
      addr_cnt_q  <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      core_rst_no <= 1'b0;
      done_o      <= 1'b0;
      ovf_err_o   <= 1'b0;
    end else begin
      mem_we_o <= 1'b0;
      if (accept) begin
        word_q <= word_c;
        lane_q <= lane_last ? '0 : lane_q + LW'(1);
        if (lane_last) begin
          if (word_c == END_WORD) begin
            done_o      <= 1'b1;
            core_rst_no <= 1'b1;
          end else if (!addr_cnt_q[ADDR_W]) begin
            mem_we_o    <= 1'b1;
            mem_addr_o  <= addr_cnt_q[ADDR_W-1:0];
            mem_wdata_o <= word_c;
            addr_cnt_q  <= addr_cnt_q + AW1'(1);
          end else begin
            ovf_err_o <= 1'b1;
          end
        end
      end
    end
  end

  // Sticky receive errors; input is ignored once loading is done.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                         frame_err_o <= 1'b0;
    else if (rx_frame_err && !done_o)    frame_err_o <= 1'b1;
  end

`ifdef UART_PROG_PARITY_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                         parity_err_o <= 1'b0;
    else if (rx_parity_err && !done_o)   parity_err_o <= 1'b1;
  end
`endif

endmodule
